// File: rtl/bram_sdp_be.sv
// Simple dual-port RAM with byte enables, write-first collision bypass and optional output register.
// Define BRAM_CLEAR_EN to zero the whole array after every reset before ready rises.
//
// state   | meaning
// S_CLEAR | sweeping zero words into the array, one address per cycle
// S_RUN   | sweep finished, array open to reads and writes
module bram_sdp_be #(
  parameter int    ADDR_WIDTH = 12,
  parameter int    DATA_WIDTH = 32,
  parameter int    OUT_REG    = 0,
  parameter string INIT_FILE  = ""
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clearing;
  logic                  run;
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef BRAM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_t;
  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr_nxt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // The counter parks at the last address instead of wrapping.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    clearing     = 1'b0;
    case (state)
      S_CLEAR: begin
        clearing = 1'b1;
        if (&clr_addr) state_nxt = S_RUN;
        else           clr_addr_nxt = clr_addr + 1'b1;
      end
      S_RUN:   ;
      default: state_nxt = S_CLEAR;
    endcase
  end

  assign run = (state == S_RUN);
`else
  assign clearing = 1'b0;
  assign run      = 1'b1;
  assign clr_addr = '0;
`endif

  // Registered so ready rises one edge after the sweep's final write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ready <= 1'b0;
    else          ready <= run;
  end

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_be;

  always_comb begin
    mem_we    = clearing | (ready & wr_en);
    mem_addr  = clearing ? clr_addr : wr_addr;
    mem_wdata = clearing ? '0 : wr_data;
    mem_be    = clearing ? '1 : wr_be;
  end

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  logic                  rd_fire;
  logic                  wr_hit;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] fwd_word;

  // Same-address write in the same cycle wins per enabled lane.
  always_comb begin
    rd_fire  = ready & rd_en;
    wr_hit   = ready & wr_en & (wr_addr == rd_addr);
    rd_word  = mem[rd_addr];
    fwd_word = rd_word;
    for (int i = 0; i < NB; i++) begin
      if (wr_hit && wr_be[i]) fwd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) s1_data <= fwd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= s1_valid;
          if (s1_valid) rd_data <= s1_data;
        end
      end
    end else begin : g_no_out_reg
      assign rd_data  = s1_data;
      assign rd_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_bram_sdp_be.sv
// Scoreboard bench for bram_sdp_be: two instances (latency 1 and 2) share one stimulus stream.
// Build with BRAM_CLEAR_EN defined to also exercise the zero-clear sweep.
module tb_bram_sdp_be;

`ifdef BRAM_CLEAR_EN
  localparam int          READY_EDGES = 17;
  localparam logic [31:0] DROP_EXP    = 32'h0000_0000;
`else
  localparam int          READY_EDGES = 1;
  localparam logic [31:0] DROP_EXP    = 32'h1234_5678;
`endif

  logic        clk, rst_n;
  logic        wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr, wr_be;
  logic [31:0] wr_data;
  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, ready0, ready1;

  bram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(0)) u0 (
    .HCLK(clk), .HRESETn(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .ready(ready0));

  bram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(1)) u1 (
    .HCLK(clk), .HRESETn(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .ready(ready1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int dchecks = 0, derrors = 0;
  int mchecks = 0, merrors = 0;
  int checks, errors;

  // Expected cycle stamps enforce both latency and single-cycle rd_valid.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0 && q0[0].cyc < cyc) begin
      e = q0.pop_front();
      mchecks++; merrors++;
      $display("FAIL rd0_missing expected %h at cyc %0d, no rd_valid by cyc %0d", e.data, e.cyc, cyc);
    end
    if (q1.size() > 0 && q1[0].cyc < cyc) begin
      e = q1.pop_front();
      mchecks++; merrors++;
      $display("FAIL rd1_missing expected %h at cyc %0d, no rd_valid by cyc %0d", e.data, e.cyc, cyc);
    end
    if (rd_valid0 === 1'b1) begin
      mchecks++;
      if (q0.size() == 0) begin
        merrors++;
        $display("FAIL rd0_unexpected got %h at cyc %0d, expected no rd_valid", rd_data0, cyc);
      end else begin
        e = q0.pop_front();
        if (rd_data0 !== e.data || cyc != e.cyc) begin
          merrors++;
          $display("FAIL rd0_data got %h at cyc %0d, expected %h at cyc %0d", rd_data0, cyc, e.data, e.cyc);
        end
      end
    end
    if (rd_valid1 === 1'b1) begin
      mchecks++;
      if (q1.size() == 0) begin
        merrors++;
        $display("FAIL rd1_unexpected got %h at cyc %0d, expected no rd_valid", rd_data1, cyc);
      end else begin
        e = q1.pop_front();
        if (rd_data1 !== e.data || cyc != e.cyc) begin
          merrors++;
          $display("FAIL rd1_data got %h at cyc %0d, expected %h at cyc %0d", rd_data1, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    dchecks++;
    if (act !== exp) begin
      derrors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  // One clock of stimulus; a read pushes its expected word for both latencies.
  task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic re, input logic [3:0] ra,
                      input logic [31:0] exp);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    if (re) begin
      q0.push_back('{data: exp, cyc: cyc + 1});
      q1.push_back('{data: exp, cyc: cyc + 2});
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Assert reset, check outputs clear immediately, release and count edges to ready.
  task automatic do_reset(input bit junk);
    int n;
    rst_n = 1'b0;
    #1;
    chk("rst_rd_data0", rd_data0, 32'h0);
    chk("rst_rd_data1", rd_data1, 32'h0);
    chk("rst_rd_valid0", {31'h0, rd_valid0}, 32'h0);
    chk("rst_rd_valid1", {31'h0, rd_valid1}, 32'h0);
    chk("rst_ready0", {31'h0, ready0}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    if (junk) begin
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h5555_5555; wr_be = 4'hF;
      rd_en = 1'b1; rd_addr = 4'd9;
    end
    n = 0;
    while (ready0 !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    idle();
    chk("ready_edges", n, READY_EDGES);
    chk("ready1", {31'h0, ready1}, 32'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rd_en = 1'b1;
    do_reset(1'b0);

    step(1, 4'd9, 32'h1234_5678, 4'hF, 0, 4'd0, 32'h0);
    step(0, 4'd0, 32'h0, 4'h0, 1, 4'd9, 32'h1234_5678);
    wait_cycles(3);
    chk("pre_reset_hold0", rd_data0, 32'h1234_5678);

    do_reset(1'b1);
    step(0, 4'd0, 32'h0, 4'h0, 1, 4'd9, DROP_EXP);

`ifdef BRAM_CLEAR_EN
    for (int a = 0; a < 16; a++) step(0, 4'd0, 32'h0, 4'h0, 1, 4'(a), 32'h0);
    step(1, 4'd3, 32'h7777_7777, 4'hF, 0, 4'd0, 32'h0);
    step(0, 4'd0, 32'h0, 4'h0, 1, 4'd3, 32'h7777_7777);
    wait_cycles(3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_cycles(8);
    do_reset(1'b1);
    step(0, 4'd0, 32'h0, 4'h0, 1, 4'd3, 32'h0);
    wait_cycles(3);
`endif

    step(1, 4'd3, 32'hDEAD_BEEF, 4'hF, 0, 4'd0, 32'h0);
    step(0, 4'd0, 32'h0, 4'h0, 1, 4'd3, 32'hDEAD_BEEF);

    step(1, 4'd5, 32'h1122_3344, 4'hF, 0, 4'd0, 32'h0);
    step(1, 4'd5, 32'hAABB_CCDD, 4'b0101, 0, 4'd0, 32'h0);
    step(0, 4'd0, 32'h0, 4'h0, 1, 4'd5, 32'h11BB_33DD);

    step(1, 4'd7, 32'h0000_0000, 4'hF, 0, 4'd0, 32'h0);
    step(1, 4'd7, 32'hCAFE_F00D, 4'b1100, 1, 4'd7, 32'hCAFE_0000);
    step(0, 4'd0, 32'h0, 4'h0, 1, 4'd7, 32'hCAFE_0000);

    step(1, 4'd0, 32'h0000_000A, 4'hF, 0, 4'd0, 32'h0);
    step(1, 4'd1, 32'h0000_000B, 4'hF, 0, 4'd0, 32'h0);
    step(1, 4'd2, 32'h0000_000C, 4'hF, 0, 4'd0, 32'h0);
    step(0, 4'd0, 32'h0, 4'h0, 1, 4'd0, 32'h0000_000A);
    step(0, 4'd0, 32'h0, 4'h0, 1, 4'd1, 32'h0000_000B);
    step(0, 4'd0, 32'h0, 4'h0, 1, 4'd2, 32'h0000_000C);

    step(1, 4'd3, 32'hFFFF_FFFF, 4'h0, 0, 4'd0, 32'h0);
    step(0, 4'd0, 32'h0, 4'h0, 1, 4'd3, 32'hDEAD_BEEF);

    step(1, 4'd1, 32'h0102_0304, 4'hF, 1, 4'd1, 32'h0102_0304);
    step(1, 4'd4, 32'h0BAD_C0DE, 4'hF, 1, 4'd3, 32'hDEAD_BEEF);
    step(0, 4'd0, 32'h0, 4'h0, 1, 4'd4, 32'h0BAD_C0DE);

    wait_cycles(4);
    chk("hold_rd_data0", rd_data0, 32'h0BAD_C0DE);
    chk("hold_rd_data1", rd_data1, 32'h0BAD_C0DE);
    chk("hold_rd_valid0", {31'h0, rd_valid0}, 32'h0);
    chk("hold_rd_valid1", {31'h0, rd_valid1}, 32'h0);
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);

    checks = dchecks + mchecks;
    errors = derrors + merrors;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
